// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO family:
//   - pointer / occupancy-count width helpers derived from DEPTH
//   - read-mode encoding (standard registered read vs first-word-fall-through)
//   - parameter legality check used at elaboration by sync_fifo_flags
// No ports (package).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package fifo_pkg;

  // Read-mode encoding carried by the FWFT parameter of sync_fifo_flags.
  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  // Pointer width: enough bits to address DEPTH entries.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Count width: one bit wider than the pointers so DEPTH itself is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // Pointers wrap by natural overflow, so DEPTH must be a power of two.
  function automatic bit params_legal(input int width,
                                      input int depth,
                                      input int af_level,
                                      input int ae_level,
                                      input int mode);
    return (width >= 1) &&
           (depth >= 2) && is_pow2(depth) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1) &&
           ((mode == int'(MODE_STD)) || (mode == int'(MODE_FWFT)));
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port storage array, WIDTH x DEPTH. Synchronous write, asynchronous
// read. Contents are intentionally not reset.
// Ports:
//   clk      rising-edge clock for the write port
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address
//   rd_data  read data (combinational from rd_addr)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [ptr_width(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [ptr_width(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]            rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: one word per accepted write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read lets the parent either register the word or present it
  // directly (first-word-fall-through).
  assign rd_data = mem[rd_addr];

endmodule : fifo_mem

// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
// Single-clock FIFO with simultaneous read/write, occupancy count, full/empty
// and programmable almost-full/almost-empty flags, overflow/underflow error
// pulses and an optional first-word-fall-through read mode.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active-high
//   wr_en / din   write request and data
//   rd_en         read request (FWFT: pop of the head word)
//   dout / valid  read data and its qualifier
//   count         occupancy 0..DEPTH
//   full / empty  count == DEPTH / count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   overflow      one-cycle pulse after a rejected write
//   underflow     one-cycle pulse after a rejected read
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

  if (!params_legal(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL, FWFT)) begin : g_param_check
    $error("sync_fifo_flags: illegal parameters WIDTH=%0d DEPTH=%0d AF_LEVEL=%0d AE_LEVEL=%0d FWFT=%0d",
           WIDTH, DEPTH, AF_LEVEL, AE_LEVEL, FWFT);
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             wr_accept;
  logic             rd_accept;
  logic [WIDTH-1:0] mem_rd_data;

  // Flags come only from the registered count, so they move on the same edge
  // as count and never see wr_en/rd_en combinationally.
  assign count        = count_q;
  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A write into a full FIFO is still taken when a read frees the slot on the
  // same edge. There is no bypass: a read of an empty FIFO is always rejected,
  // even if a write arrives in the same cycle.
  always_comb begin
    rd_accept = rd_en && !empty;
    wr_accept = wr_en && (!full || rd_accept);
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  // Pointers, occupancy and the error pulses. Pointers wrap DEPTH-1 -> 0 by
  // natural overflow of their PTR_W bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= wr_en && !wr_accept;
      underflow_q <= rd_en && !rd_accept;

      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      unique case ({wr_accept, rd_accept})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  if (FWFT == int'(MODE_FWFT)) begin : g_fwft
    // Head word is shown continuously; popping advances rd_ptr so the next
    // word (or valid=0) appears on the same edge.
    assign dout  = mem_rd_data;
    assign valid = !empty;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;

    // Registered read: the word is captured on the accepting edge and dout
    // holds it until the next accepted read; valid marks only that cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_accept;
        if (rd_accept) begin
          dout_q <= mem_rd_data;
        end
      end
    end

    assign dout  = dout_q;
    assign valid = valid_q;
  end

  // Occupancy can never exceed DEPTH, and full/empty are mutually exclusive.
  a_count_range : assert property (@(posedge clk) disable iff (rst) count_q <= CNT_FULL);
  a_full_empty  : assert property (@(posedge clk) disable iff (rst) !(full && empty));

endmodule : sync_fifo_flags

// File: tb/tb_sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flags
// Self-checking bench for sync_fifo_flags. Two instances share the clock: one in
// standard registered-read mode, one in first-word-fall-through mode. A queue
// model tracks FIFO contents; words leaving the model on accepted reads are
// pushed to a scoreboard and popped when the DUT raises valid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sync_fifo_flags;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = 6;
  localparam int AE_LEVEL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // standard-mode instance signals
  logic             s_rst = 1'b1;
  logic             s_wr_en = 1'b0;
  logic [WIDTH-1:0] s_din = '0;
  logic             s_rd_en = 1'b0;
  logic [WIDTH-1:0] s_dout;
  logic             s_valid;
  logic [3:0]       s_count;
  logic             s_full, s_empty, s_af, s_ae, s_ovf, s_unf;

  // FWFT-mode instance signals
  logic             f_rst = 1'b1;
  logic             f_wr_en = 1'b0;
  logic [WIDTH-1:0] f_din = '0;
  logic             f_rd_en = 1'b0;
  logic [WIDTH-1:0] f_dout;
  logic             f_valid;
  logic [3:0]       f_count;
  logic             f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

  sync_fifo_flags #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FWFT(0)
  ) dut_std (
    .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .din(s_din), .rd_en(s_rd_en),
    .dout(s_dout), .valid(s_valid), .count(s_count), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_flags #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FWFT(1)
  ) dut_fwft (
    .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en),
    .dout(f_dout), .valid(f_valid), .count(f_count), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_unf)
  );

  int checks = 0;
  int errors = 0;

  // standard-mode model and scoreboard
  logic [WIDTH-1:0] std_q[$];
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] exp_dout = '0;
  bit               exp_valid = 1'b0;
  bit               exp_ovf = 1'b0;
  bit               exp_unf = 1'b0;

  // FWFT-mode model
  logic [WIDTH-1:0] fw_q[$];
  bit               fexp_ovf = 1'b0;
  bit               fexp_unf = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // One clock of the standard-mode instance: drive, update model, sample #1 after the edge.
  task automatic applyStimulus(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit rs);
    bit rd_acc;
    bit wr_acc;
    logic [WIDTH-1:0] got;
    s_wr_en = w;
    s_din   = d;
    s_rd_en = r;
    s_rst   = rs;
    if (rs) begin
      std_q.delete();
      exp_dout  = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
    end else begin
      rd_acc    = r && (std_q.size() != 0);
      wr_acc    = w && ((std_q.size() < DEPTH) || rd_acc);
      exp_ovf   = w && !wr_acc;
      exp_unf   = r && !rd_acc;
      exp_valid = rd_acc;
      if (rd_acc) sb_q.push_back(std_q.pop_front());
      if (wr_acc) std_q.push_back(d);
    end
    @(posedge clk);
    #1;
    s_wr_en = 1'b0;
    s_rd_en = 1'b0;
    s_rst   = 1'b0;
    checkOutput("count",        32'(s_count), 32'(std_q.size()));
    checkOutput("full",         32'(s_full),  32'(std_q.size() == DEPTH));
    checkOutput("empty",        32'(s_empty), 32'(std_q.size() == 0));
    checkOutput("almost_full",  32'(s_af),    32'(std_q.size() >= AF_LEVEL));
    checkOutput("almost_empty", 32'(s_ae),    32'(std_q.size() <= AE_LEVEL));
    checkOutput("overflow",     32'(s_ovf),   32'(exp_ovf));
    checkOutput("underflow",    32'(s_unf),   32'(exp_unf));
    checkOutput("valid",        32'(s_valid), 32'(exp_valid));
    if (s_valid) begin
      checkOutput("sb_has_entry", 32'(sb_q.size() != 0), 32'(1));
      if (sb_q.size() != 0) begin
        got = sb_q.pop_front();
        exp_dout = got;
      end
    end
    checkOutput("dout", 32'(s_dout), 32'(exp_dout));
  endtask

  // One clock of the FWFT instance.
  task automatic applyFwft(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit rs);
    bit rd_acc;
    bit wr_acc;
    f_wr_en = w;
    f_din   = d;
    f_rd_en = r;
    f_rst   = rs;
    if (rs) begin
      fw_q.delete();
      fexp_ovf = 1'b0;
      fexp_unf = 1'b0;
    end else begin
      rd_acc   = r && (fw_q.size() != 0);
      wr_acc   = w && ((fw_q.size() < DEPTH) || rd_acc);
      fexp_ovf = w && !wr_acc;
      fexp_unf = r && !rd_acc;
      if (rd_acc) void'(fw_q.pop_front());
      if (wr_acc) fw_q.push_back(d);
    end
    @(posedge clk);
    #1;
    f_wr_en = 1'b0;
    f_rd_en = 1'b0;
    f_rst   = 1'b0;
    checkOutput("f_count",     32'(f_count), 32'(fw_q.size()));
    checkOutput("f_empty",     32'(f_empty), 32'(fw_q.size() == 0));
    checkOutput("f_full",      32'(f_full),  32'(fw_q.size() == DEPTH));
    checkOutput("f_valid",     32'(f_valid), 32'(fw_q.size() != 0));
    checkOutput("f_underflow", 32'(f_unf),   32'(fexp_unf));
    checkOutput("f_overflow",  32'(f_ovf),   32'(fexp_ovf));
    if (fw_q.size() != 0) begin
      checkOutput("f_dout", 32'(f_dout), 32'(fw_q[0]));
    end
  endtask

  initial begin
    $display("[TB] start");

    // reset; the write requested during reset must be discarded
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);

    // fill 0x11..0x88, then a rejected 9th write
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i * 17), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // drain 8, then a rejected 9th read
    repeat (9) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // simultaneous read/write at count=4
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h35 + i), 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // simultaneous read/write at full
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h49 + i), 1'b1, 1'b0);
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // simultaneous read/write at empty: write taken, read rejected
    applyStimulus(1'b1, 8'h5C, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // pointer wrap
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // reset mid-operation with a write request, then a read of the empty FIFO
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h71 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'(0));

    // first-word-fall-through instance
    applyFwft(1'b0, 8'h00, 1'b0, 1'b1);
    applyFwft(1'b1, 8'hA5, 1'b0, 1'b0);
    applyFwft(1'b1, 8'h5A, 1'b0, 1'b0);
    applyFwft(1'b0, 8'h00, 1'b1, 1'b0);
    applyFwft(1'b0, 8'h00, 1'b1, 1'b0);
    applyFwft(1'b0, 8'h00, 1'b1, 1'b0);
    applyFwft(1'b0, 8'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sync_fifo_flags
